cmac_rx_drop_fifo: RTL and testbench

Store-and-forward frame buffer on the `net_clk` receive path. It sits directly downstream of the CMAC RX AXI-Stream output and upstream of the RX register slice and clock-crossing FIFO. The CMAC RX port cannot be back-pressured, so this block absorbs downstream stalls. It forwards only complete, error-free frames and drops a whole frame when it is errored or the buffer overflows.

---
 rtl/cmac_rx_drop_fifo_pkg.sv | 19 +
 rtl/cmac_rx_drop_fifo_ram.sv | 38 +++
 rtl/cmac_rx_drop_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_cmac_rx_drop_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmac_rx_drop_fifo_pkg.sv
// Shared constants and types for the CMAC RX drop FIFO.
package cmac_rx_drop_fifo_pkg;

  // 512-bit network stream used across the RX datapath
  localparam int unsigned NET_AXIS_DATA_W = 512;
  localparam int unsigned NET_AXIS_KEEP_W = NET_AXIS_DATA_W / 8;

  // Default buffer sizing and statistics width
  localparam int unsigned RX_FIFO_DEPTH = 128;
  localparam int unsigned RX_CNT_W      = 32;

  // Input-side frame acceptance state
  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_PASS   = 2'd1,
    ST_DROP   = 2'd2
  } rx_state_e;

endpackage

// File: rtl/cmac_rx_drop_fifo_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module cmac_rx_drop_fifo_ram #(
  parameter int unsigned WIDTH  = 577,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              net_clk,
  input  logic              sys_reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port; storage is never reset so it maps onto block RAM
  always_ff @(posedge net_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; output register resets so downstream sees zeros after reset
  always_ff @(posedge net_clk or posedge sys_reset) begin
    if (sys_reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cmac_rx_drop_fifo.sv
// Store-and-forward RX frame buffer: commits good frames, drops errored or overflowing ones.
module cmac_rx_drop_fifo
  import cmac_rx_drop_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = NET_AXIS_DATA_W,
  parameter int unsigned DEPTH  = RX_FIFO_DEPTH,
  parameter int unsigned CNT_W  = RX_CNT_W
) (
  input  logic                net_clk,
  input  logic                sys_reset,
  input  logic                s_axis_tvalid,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic [CNT_W-1:0]    frames_ok,
  output logic [CNT_W-1:0]    frames_err,
  output logic [CNT_W-1:0]    frames_ovf,
  output logic                drop_pulse
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned ENT_W  = DATA_W + KEEP_W + 1;

  rx_state_e          state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   ok_q, ok_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   ovf_q, ovf_d;
  logic               drop_q, drop_d;

  logic               sk_vld_q, sk_vld_d;
  logic [ENT_W-1:0]   sk_q, sk_d;
  logic               rv_q, rv_d;

  logic               full_c;
  logic               ram_we_c;
  logic               avail_c;
  logic               pop_c;
  logic               rd_en_c;
  logic [1:0]         occ_c;
  logic [ENT_W-1:0]   ram_wdata_c;
  logic [ENT_W-1:0]   ram_rdata;
  logic [ENT_W-1:0]   head_c;

  // Full uses this cycle's rd_ptr; a same-cycle read frees space only next cycle
  assign full_c      = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign avail_c     = rd_ptr_q != commit_ptr_q;
  assign ram_wdata_c = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  cmac_rx_drop_fifo_ram #(
    .WIDTH  (ENT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_ram (
    .net_clk   (net_clk),
    .sys_reset (sys_reset),
    .wr_en     (ram_we_c),
    .wr_addr   (wr_ptr_q[AW-1:0]),
    .wr_data   (ram_wdata_c),
    .rd_en     (rd_en_c),
    .rd_addr   (rd_ptr_q[AW-1:0]),
    .rd_data   (ram_rdata)
  );

  // Input FSM: tentative writes, commit on good tlast, rewind on error or overflow
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    ok_d         = ok_q;
    err_d        = err_q;
    ovf_d        = ovf_q;
    drop_d       = 1'b0;
    ram_we_c     = 1'b0;
    case (state_q)
      ST_RESYNC: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        if (s_axis_tvalid) begin
          if (!full_c) begin
            ram_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_axis_tlast) begin
              if (s_axis_tuser) begin
                wr_ptr_d = commit_ptr_q;
                err_d    = err_q + CNT_W'(1);
                drop_d   = 1'b1;
              end else begin
                commit_ptr_d = wr_ptr_q + PW'(1);
                ok_d         = ok_q + CNT_W'(1);
              end
            end
          end else begin
            wr_ptr_d = commit_ptr_q;
            if (s_axis_tlast) begin
              ovf_d  = ovf_q + CNT_W'(1);
              drop_d = 1'b1;
            end else begin
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          ovf_d   = ovf_q + CNT_W'(1);
          drop_d  = 1'b1;
          state_d = ST_PASS;
        end
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  // Input-side state, pointers and statistics
  always_ff @(posedge net_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q      <= ST_RESYNC;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      ok_q         <= '0;
      err_q        <= '0;
      ovf_q        <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
    end
  end

  // Output stage: RAM read register plus one skid entry; skid is the head when valid
  assign m_axis_tvalid = sk_vld_q | rv_q;
  assign head_c        = sk_vld_q ? sk_q : ram_rdata;
  assign pop_c         = m_axis_tvalid & m_axis_tready;

  // Read issue and skid bookkeeping; never more than two beats held past the RAM
  always_comb begin
    sk_vld_d = sk_vld_q;
    sk_d     = sk_q;
    rv_d     = rv_q;
    rd_ptr_d = rd_ptr_q;
    rd_en_c  = 1'b0;
    occ_c    = 2'(sk_vld_q) + 2'(rv_q) - 2'(pop_c);
    if (avail_c && (occ_c < 2'd2)) begin
      rd_en_c  = 1'b1;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({sk_vld_q, rv_q})
      2'b00: rv_d = rd_en_c;
      2'b01: begin
        if (pop_c) begin
          rv_d = rd_en_c;
        end else if (rd_en_c) begin
          // Park the stalled RAM beat before the next read overwrites it
          sk_d     = ram_rdata;
          sk_vld_d = 1'b1;
        end
      end
      2'b10: begin
        rv_d = rd_en_c;
        if (pop_c) begin
          sk_vld_d = 1'b0;
        end
      end
      default: begin
        if (pop_c) begin
          if (rd_en_c) begin
            sk_d = ram_rdata;
          end else begin
            sk_vld_d = 1'b0;
          end
        end
      end
    endcase
  end

  // Read pointer and output stage registers
  always_ff @(posedge net_clk or posedge sys_reset) begin
    if (sys_reset) begin
      rd_ptr_q <= '0;
      sk_vld_q <= 1'b0;
      sk_q     <= '0;
      rv_q     <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      sk_vld_q <= sk_vld_d;
      sk_q     <= sk_d;
      rv_q     <= rv_d;
    end
  end

  assign m_axis_tdata = head_c[DATA_W-1:0];
  assign m_axis_tkeep = head_c[DATA_W +: KEEP_W];
  assign m_axis_tlast = head_c[ENT_W-1];
  assign frames_ok    = ok_q;
  assign frames_err   = err_q;
  assign frames_ovf   = ovf_q;
  assign drop_pulse   = drop_q;

endmodule

// File: tb/tb_cmac_rx_drop_fifo.sv
// Directed and random-stall checks for cmac_rx_drop_fifo (DATA_W=64, DEPTH=8).
module tb_cmac_rx_drop_fifo;

  localparam int unsigned DW    = 64;
  localparam int unsigned KW    = DW / 8;
  localparam int unsigned DEP   = 8;
  localparam int unsigned CW    = 32;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic          net_clk = 1'b0;
  logic          sys_reset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [CW-1:0] frames_ok;
  logic [CW-1:0] frames_err;
  logic [CW-1:0] frames_ovf;
  logic          drop_pulse;

  cmac_rx_drop_fifo #(
    .DATA_W (DW),
    .DEPTH  (DEP),
    .CNT_W  (CW)
  ) dut (
    .net_clk       (net_clk),
    .sys_reset     (sys_reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .frames_ok     (frames_ok),
    .frames_err    (frames_err),
    .frames_ovf    (frames_ovf),
    .drop_pulse    (drop_pulse)
  );

  always #5 net_clk = ~net_clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    last_cyc = 0;
  int    first_vld_cyc = -1;
  int    last_drop_cyc = -1;
  int    drops = 0;
  int    rx_beats = 0;
  int    rx_frames = 0;
  int    tready_mode = 0;
  beat_t exp_q[$];
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [KW-1:0] keep_of(input int id);
    return 8'hFF >> (id % 8);
  endfunction

  always @(posedge net_clk) cyc <= cyc + 1;

  // Downstream ready: held low, held high, or random per cycle
  always @(posedge net_clk) begin
    #1;
    case (tready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: scoreboard compare, hold-while-stalled, drop pulse tracking
  always @(negedge net_clk) begin
    beat_t got;
    beat_t e;
    got = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    if (sys_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (drop_pulse) begin
        drops++;
        last_drop_cyc = cyc;
      end
      if (m_axis_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (prev_stall) begin
        check("hold_valid", 128'(m_axis_tvalid), 128'(1));
        check("hold_beat", 128'(got), 128'(prev_beat));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 128'(got), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 128'(got), 128'(e));
        end
        rx_beats++;
        if (m_axis_tlast) rx_frames++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = got;
    end
  end

  task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic u);
    @(posedge net_clk);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge net_clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
    end
  endtask

  task automatic send_frame(input int id, input int len, input logic user, input logic good);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    for (int i = 0; i < len; i++) begin
      d = {32'(id), 32'(i)};
      l = (i == len - 1);
      k = l ? keep_of(id) : 8'hFF;
      beat(d, k, l, l & user);
      if (good) exp_q.push_back({l, k, d});
    end
    last_cyc = cyc;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge net_clk);
      n++;
    end
    check("drain", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int nok;
    int nerr;
    int d0;
    int f0;
    int b0;
    int err_last;

    // Reset values
    repeat (3) @(posedge net_clk);
    #1;
    check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_tdata", 128'(m_axis_tdata), 128'(0));
    check("rst_tkeep", 128'(m_axis_tkeep), 128'(0));
    check("rst_tlast", 128'(m_axis_tlast), 128'(0));
    check("rst_ok", 128'(frames_ok), 128'(0));
    check("rst_err", 128'(frames_err), 128'(0));
    check("rst_ovf", 128'(frames_ovf), 128'(0));
    check("rst_drop", 128'(drop_pulse), 128'(0));
    sys_reset = 1'b0;
    idle(2);

    // Resync frame after reset is swallowed without counting
    send_frame(99, 1, 1'b0, 1'b0);
    idle(4);
    check("resync_ok", 128'(frames_ok), 128'(0));
    check("resync_out", 128'(m_axis_tvalid), 128'(0));
    check("resync_drops", 128'(drops), 128'(0));

    // 4-beat good frame, output latency L+2
    tready_mode = 1;
    idle(1);
    first_vld_cyc = -1;
    send_frame(1, 4, 1'b0, 1'b1);
    idle(1);
    wait_drain(100);
    check("t1_latency", 128'(first_vld_cyc), 128'(last_cyc + 2));
    check("t1_ok", 128'(frames_ok), 128'(1));
    check("t1_frames", 128'(rx_frames), 128'(1));
    check("t1_beats", 128'(rx_beats), 128'(4));

    // Errored frame dropped, following good frame passes
    d0 = drops;
    send_frame(2, 3, 1'b1, 1'b0);
    err_last = last_cyc;
    send_frame(3, 2, 1'b0, 1'b1);
    idle(2);
    wait_drain(100);
    check("t2_err", 128'(frames_err), 128'(1));
    check("t2_ok", 128'(frames_ok), 128'(2));
    check("t2_drops", 128'(drops - d0), 128'(1));
    check("t2_drop_cyc", 128'(last_drop_cyc), 128'(err_last + 1));
    check("t2_frames", 128'(rx_frames), 128'(2));

    // Stalled output: two 4-beat frames fill the buffer, the third overflows
    tready_mode = 0;
    idle(2);
    send_frame(4, 4, 1'b0, 1'b1);
    send_frame(5, 4, 1'b0, 1'b1);
    send_frame(6, 4, 1'b0, 1'b0);
    idle(4);
    check("t3_ok", 128'(frames_ok), 128'(4));
    check("t3_ovf", 128'(frames_ovf), 128'(1));
    check("t3_stalled_vld", 128'(m_axis_tvalid), 128'(1));
    b0 = rx_beats;
    f0 = rx_frames;
    tready_mode = 1;
    idle(1);
    wait_drain(100);
    idle(4);
    check("t3_beats", 128'(rx_beats - b0), 128'(8));
    check("t3_frames", 128'(rx_frames - f0), 128'(2));

    // Frame longer than the buffer is dropped; the next 1-beat frame passes
    send_frame(7, 10, 1'b0, 1'b0);
    send_frame(8, 1, 1'b0, 1'b1);
    idle(2);
    wait_drain(100);
    idle(3);
    check("t4_ovf", 128'(frames_ovf), 128'(2));
    check("t4_ok", 128'(frames_ok), 128'(5));
    check("t4_frames", 128'(rx_frames), 128'(5));

    // Reset mid-operation clears output, counters; tail after release is discarded
    tready_mode = 0;
    idle(1);
    send_frame(9, 2, 1'b0, 1'b1);
    idle(4);
    check("t5_pre_vld", 128'(m_axis_tvalid), 128'(1));
    beat({32'd10, 32'd0}, 8'hFF, 1'b0, 1'b0);
    beat({32'd10, 32'd1}, 8'hFF, 1'b0, 1'b0);
    @(posedge net_clk);
    #2;
    sys_reset = 1'b1;
    #1;
    exp_q.delete();
    check("t5_rst_vld", 128'(m_axis_tvalid), 128'(0));
    check("t5_rst_data", 128'(m_axis_tdata), 128'(0));
    check("t5_rst_ok", 128'(frames_ok), 128'(0));
    @(posedge net_clk);
    #1;
    sys_reset = 1'b0;
    s_axis_tdata = {32'd10, 32'd2};
    beat({32'd10, 32'd3}, 8'hFF, 1'b0, 1'b0);
    beat({32'd10, 32'd4}, 8'hFF, 1'b1, 1'b0);
    idle(4);
    check("t5_tail_ok", 128'(frames_ok), 128'(0));
    check("t5_tail_err", 128'(frames_err), 128'(0));
    check("t5_tail_ovf", 128'(frames_ovf), 128'(0));
    check("t5_tail_vld", 128'(m_axis_tvalid), 128'(0));
    tready_mode = 1;
    send_frame(11, 3, 1'b0, 1'b1);
    idle(2);
    wait_drain(100);
    check("t5_ok", 128'(frames_ok), 128'(1));
    check("t5_frames", 128'(rx_frames), 128'(6));

    // Random lengths, random errors, random ready; admit frames only when they fit
    nok  = 0;
    nerr = 0;
    d0   = drops;
    f0   = rx_frames;
    tready_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      int   len;
      int   n;
      logic er;
      len = $urandom_range(1, 8);
      er  = ($urandom_range(0, 3) == 0);
      n   = 0;
      while ((exp_q.size() + len > 8) && n < 1000) begin
        idle(1);
        n++;
      end
      if (n >= 1000) check("space_wait", 128'(n), 128'(0));
      send_frame(100 + f, len, er, !er);
      if (er) nerr++;
      else    nok++;
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
    wait_drain(5000);
    idle(4);
    check("t6_ok", 128'(frames_ok), 128'(1 + nok));
    check("t6_err", 128'(frames_err), 128'(nerr));
    check("t6_ovf", 128'(frames_ovf), 128'(0));
    check("t6_drops", 128'(drops - d0), 128'(nerr));
    check("t6_frames", 128'(rx_frames - f0), 128'(nok));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
